// File: rtl/alu_pkg.sv
// ============================================================================
// Module : alu_pkg
// Brief  : Opcode encodings and width constant shared by the 32-bit ALU.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam int unsigned ALU_WIDTH = 32;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_MUL  = 4'b0010;
    localparam logic [3:0] ALU_AND  = 4'b0011;
    localparam logic [3:0] ALU_OR   = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SEQ  = 4'b0110;
    localparam logic [3:0] ALU_SNE  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b1001;
    localparam logic [3:0] ALU_ROTR = 4'b1010;
    localparam logic [3:0] ALU_CLO  = 4'b1011;
    localparam logic [3:0] ALU_CLZ  = 4'b1100;

endpackage

`default_nettype wire

// File: rtl/alu_lead_count.sv
// ============================================================================
// Module : alu_lead_count
// Brief  : Combinational leading-zero counter, 32-bit input, result 0..32.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_lead_count
    import alu_pkg::*;
(
    input  logic [ALU_WIDTH-1:0] i_value,
    output logic [5:0]           o_count
);

    // Scanning upward lets the highest set bit make the final assignment.
    always_comb begin
        o_count = 6'd32;
        for (int i = 0; i < 32; i++) begin
            if (i_value[i]) begin
                o_count = 6'(31 - i);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_32bit.sv
// ============================================================================
// Module : alu_32bit
// Brief  : Registered 32-bit ALU, 13 opcodes, one-cycle latency, Zero flag.
//          Define ALU_OVERFLOW_EN to add a registered signed Overflow output.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_32bit
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [3:0]       ALUControl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] ALUResult,
`ifdef ALU_OVERFLOW_EN
    output logic             Overflow,
`endif
    output logic             Zero
);

    localparam int unsigned c_shw = $clog2(WIDTH);

    logic [c_shw-1:0] w_shamt;
    logic [c_shw:0]   w_rot_inv;
    logic [c_shw:0]   w_clz;
    logic [c_shw:0]   w_clo;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_next;
    logic             w_zero;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;

    assign w_shamt   = B[c_shw-1:0];
    // A left shift by the full width yields 0, so rotate-by-0 returns A.
    assign w_rot_inv = (c_shw+1)'(WIDTH) - {1'b0, w_shamt};
    assign w_sum     = A + B;
    assign w_diff    = A - B;

    alu_lead_count u_clz (
        .i_value (A),
        .o_count (w_clz)
    );

    alu_lead_count u_clo (
        .i_value (~A),
        .o_count (w_clo)
    );

    always_comb begin
        w_next = '0;
        case (ALUControl)
            ALU_ADD:  w_next = w_sum;
            ALU_SUB:  w_next = w_diff;
            ALU_MUL:  w_next = A * B;
            ALU_AND:  w_next = A & B;
            ALU_OR:   w_next = A | B;
            ALU_SLT:  w_next = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            ALU_SEQ:  w_next = {{(WIDTH-1){1'b0}}, (A == B)};
            ALU_SNE:  w_next = {{(WIDTH-1){1'b0}}, (A != B)};
            ALU_SRL:  w_next = A >> w_shamt;
            ALU_SLL:  w_next = A << w_shamt;
            ALU_ROTR: w_next = (A >> w_shamt) | (A << w_rot_inv);
            ALU_CLO:  w_next = {{(WIDTH-c_shw-1){1'b0}}, w_clo};
            ALU_CLZ:  w_next = {{(WIDTH-c_shw-1){1'b0}}, w_clz};
            default:  w_next = '0;
        endcase
    end

    assign w_zero = (w_next == '0);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_result <= '0;
            r_zero   <= 1'b1;
        end else begin
            r_result <= w_next;
            r_zero   <= w_zero;
        end
    end

    assign ALUResult = r_result;
    assign Zero      = r_zero;

`ifdef ALU_OVERFLOW_EN
    logic w_ovf;
    logic r_ovf;

    always_comb begin
        w_ovf = 1'b0;
        case (ALUControl)
            ALU_ADD: w_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);
            ALU_SUB: w_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (w_diff[WIDTH-1] != A[WIDTH-1]);
            default: w_ovf = 1'b0;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_ovf <= 1'b0;
        end else begin
            r_ovf <= w_ovf;
        end
    end

    assign Overflow = r_ovf;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_32bit.sv
// ============================================================================
// Module : tb_alu_32bit
// Brief  : Self-checking bench for alu_32bit: directed cases plus random ops
//          against a behavioural model. Honours ALU_OVERFLOW_EN when defined.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_32bit;

    logic        Clk;
    logic        Reset;
    logic [3:0]  ALUControl;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] ALUResult;
    logic        Zero;
`ifdef ALU_OVERFLOW_EN
    logic        Overflow;
`endif

    int checks   = 0;
    int failures = 0;

    alu_32bit dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .ALUControl (ALUControl),
        .A          (A),
        .B          (B),
        .ALUResult  (ALUResult),
`ifdef ALU_OVERFLOW_EN
        .Overflow   (Overflow),
`endif
        .Zero       (Zero)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference model written from the opcode definitions, one bit at a time.
    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        logic [31:0] t;
        int          n;
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
            4'd3:  return a & b;
            4'd4:  return a | b;
            4'd5:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6:  return (a == b) ? 32'd1 : 32'd0;
            4'd7:  return (a != b) ? 32'd1 : 32'd0;
            4'd8:  return a >> b[4:0];
            4'd9:  return a << b[4:0];
            4'd10: begin
                t = a;
                for (int k = 0; k < int'(b[4:0]); k++) t = {t[0], t[31:1]};
                return t;
            end
            4'd11: begin
                n = 0;
                while (n < 32 && a[31-n] == 1'b1) n++;
                return 32'(n);
            end
            4'd12: begin
                n = 0;
                while (n < 32 && a[31-n] == 1'b0) n++;
                return 32'(n);
            end
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic model_ovf(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (op == 4'd0) r = sa + sb;
        else if (op == 4'd1) r = sa - sb;
        else return 1'b0;
        return (r > 64'sd2147483647) || (r < -64'sd2147483648);
    endfunction

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Apply one operation, advance exactly one edge, then check the registered outputs.
    task automatic step(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
        ALUControl = op;
        A = a;
        B = b;
        @(posedge Clk);
        #1;
        check32({tag, ".result"}, ALUResult, exp);
        check1({tag, ".zero"}, Zero, (exp == 32'd0));
`ifdef ALU_OVERFLOW_EN
        check1({tag, ".ovf"}, Overflow, model_ovf(op, a, b));
`endif
    endtask

    initial begin
        logic [3:0]  op;
        logic [31:0] ra, rb;

        Reset      = 1'b1;
        ALUControl = 4'b0000;
        A          = 32'd5;
        B          = 32'd5;
        for (int i = 0; i < 2; i++) begin
            @(posedge Clk);
            #1;
            check32("reset.result", ALUResult, 32'd0);
            check1("reset.zero", Zero, 1'b1);
`ifdef ALU_OVERFLOW_EN
            check1("reset.ovf", Overflow, 1'b0);
`endif
        end
        Reset = 1'b0;
        step("rel_add", 4'b0000, 32'd5, 32'd5, 32'h0000000A);

        // Each step changes the opcode, so these also run back to back.
        step("add",      4'b0000, 32'h3E8, 32'h112, 32'h000004FA);
        step("add_wrap", 4'b0000, 32'hFFFFFFFF, 32'h1, 32'h00000000);
        step("add_ovf",  4'b0000, 32'h7FFFFFFF, 32'h1, 32'h80000000);
        step("sub",      4'b0001, 32'h112, 32'h3E8, 32'hFFFFFD2A);
        step("sub_zero", 4'b0001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000);
        step("sub_ovf",  4'b0001, 32'h80000000, 32'h1, 32'h7FFFFFFF);
        step("mul",      4'b0010, 32'h3E8, 32'h112, 32'h00042E50);
        step("mul_hi",   4'b0010, 32'hFFFF0000, 32'hF, 32'hFFF10000);
        step("mul_neg",  4'b0010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001);
        step("and",      4'b0011, 32'hFFFF0000, 32'hF, 32'h00000000);
        step("or",       4'b0100, 32'h3E8, 32'h112, 32'h000003FA);
        step("slt_gt",   4'b0101, 32'h3E8, 32'h112, 32'd0);
        step("slt_lt",   4'b0101, 32'h112, 32'h3E8, 32'd1);
        step("slt_sgn",  4'b0101, 32'hFFFFFFFF, 32'h1, 32'd1);
        step("slt_eq",   4'b0101, 32'h1234, 32'h1234, 32'd0);
        step("seq",      4'b0110, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1);
        step("seq_ne",   4'b0110, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd0);
        step("sne_eq",   4'b0111, 32'hABCD, 32'hABCD, 32'd0);
        step("sne_ne",   4'b0111, 32'hABCD, 32'hABCE, 32'd1);
        step("srl1",     4'b1000, 32'hFED, 32'd1, 32'h000007F6);
        step("srl10",    4'b1000, 32'hFED, 32'd10, 32'h00000003);
        step("srl_hib",  4'b1000, 32'hFED, 32'hFFFFFFE1, 32'h000007F6);
        step("sll1",     4'b1001, 32'hFED, 32'd1, 32'h00001FDA);
        step("sll10",    4'b1001, 32'hFED, 32'd10, 32'h003FB400);
        step("rotr1",    4'b1010, 32'hFED, 32'd1, 32'h800007F6);
        step("rotr10",   4'b1010, 32'hFED, 32'd10, 32'hFB400003);
        step("rotr0",    4'b1010, 32'hFED, 32'h00000020, 32'h00000FED);
        step("clo28",    4'b1011, 32'hFFFFFFF1, 32'd0, 32'd28);
        step("clo32",    4'b1011, 32'hFFFFFFFF, 32'd0, 32'd32);
        step("clo0",     4'b1011, 32'h00000003, 32'd0, 32'd0);
        step("clz30",    4'b1100, 32'h00000003, 32'd0, 32'd30);
        step("clz4",     4'b1100, 32'h08000003, 32'd0, 32'd4);
        step("clz0",     4'b1100, 32'hC0000003, 32'd0, 32'd0);
        step("clz32",    4'b1100, 32'h00000000, 32'd0, 32'd32);
        step("op13",     4'b1101, 32'h3E8, 32'h112, 32'd0);
        step("op15",     4'b1111, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0);

        // Reset landing mid-stream must override the operation in flight.
        Reset = 1'b1;
        step("reset_mid", 4'b0100, 32'h1, 32'h2, 32'd0);
        Reset = 1'b0;

        for (int i = 0; i < 300; i++) begin
            op = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: ra = 32'hFFFFFFFF >> $urandom_range(0, 31);
                1: ra = ~(32'hFFFFFFFF >> $urandom_range(0, 31));
                2: rb = ra;
                default: ;
            endcase
            step("rand", op, ra, rb, model(op, ra, rb));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_32bit.md
Name: alu_32bit

Overview:
32-bit registered ALU for the single-cycle/pipelined datapath execute stage.
- Computes one of 13 operations on operands A and B, selected by a 4-bit ALUControl code.
- Result and Zero flag are registered on the rising edge of Clk.
- Downstream logic (branch compare, writeback mux) consumes them one cycle after the inputs are applied.

Parameters:
WIDTH, 32, operand/result width; only 32 is supported (shift amount and count widths are derived from it).

Ports:
Clk  input  1  system clock; all state updates on rising edge
Reset  input  1  synchronous, active-high reset
ALUControl  input  4  operation select
A  input  32  operand A
B  input  32  operand B (shift/rotate amount uses B[4:0])
ALUResult  output  32  registered result
Zero  output  1  registered flag; 1 when ALUResult == 0

Behaviour:
- Reset: synchronous, active-high. At any rising Clk edge with Reset=1, ALUResult <= 0 and Zero <= 1; this overrides any operation in flight.
- Latency: exactly 1 cycle; no handshake. A new operation is accepted every cycle and inputs are sampled at each rising edge.
- Zero is computed from the next-result value and registered together with it, so it is always consistent with ALUResult.
- Opcodes (all arithmetic is modulo 2^32; no traps or flags other than Zero):
  - 0000 ADD: A+B, carry out discarded.
  - 0001 SUB: A-B, two's complement wrap.
  - 0010 MUL: low 32 bits of A*B; the signed and unsigned low halves are identical.
  - 0011 AND: A&B.
  - 0100 OR: A|B.
  - 0101 SLT: 1 if $signed(A) < $signed(B), else 0.
  - 0110 SEQ: 1 if A==B, else 0.
  - 0111 SNE: 1 if A!=B, else 0.
  - 1000 SRL: A >> B[4:0], logical, zero fill.
  - 1001 SLL: A << B[4:0].
  - 1010 ROTR: A rotated right by B[4:0]; an amount of 0 returns A.
  - 1011 CLO: count of leading 1s in A starting from bit 31, range 0..32.
  - 1100 CLZ: count of leading 0s in A starting from bit 31, range 0..32.
  - 1101..1111: result 0, so Zero=1.
- Boundaries:
  - B[31:5] is ignored for SRL, SLL and ROTR.
  - CLO of all-ones returns 32; CLZ of all-zeros returns 32.
  - Set-type results are zero-extended to 32 bits.

Optional Feature:
ALU_OVERFLOW_EN
- Defined: adds output port Overflow (1 bit), registered alongside ALUResult.
  - Set to 1 for ADD when the signed operands have equal signs and the result sign differs.
  - Set to 1 for SUB when the signed operands have different signs and the result sign differs from A.
  - 0 for all other opcodes.
  - Reset value 0.
- Not defined: the port and its logic are absent. ALUResult and Zero behaviour is identical in both builds.

Decomposition:
- Package alu_pkg holds:
  - 4-bit opcode localparams (ALU_ADD, ALU_SUB, ALU_MUL, ALU_AND, ALU_OR, ALU_SLT, ALU_SEQ, ALU_SNE, ALU_SRL, ALU_SLL, ALU_ROTR, ALU_CLO, ALU_CLZ).
  - Width constant 32.
- Sub-module alu_lead_count: combinational leading-zero counter (32-bit in, 6-bit out).
  - CLZ uses A directly; CLO feeds ~A into the same counter.
- Top level holds the opcode mux, the shared Zero detect and the output registers.

Test Plan:
- Reset: hold Reset=1 for 2 edges with ADD of 5+5 applied -> ALUResult=0, Zero=1. Release Reset -> ALUResult=0x0000000A after the next edge.
- ADD/SUB:
  - ADD 0x3E8+0x112 -> 0x000004FA.
  - ADD 0xFFFFFFFF+0x1 -> 0x00000000, Zero=1.
  - SUB 0x112-0x3E8 -> 0xFFFFFD2A.
  - SUB 0xFFFFFFFF-0xFFFFFFFF -> 0, Zero=1.
- MUL/logic:
  - MUL 0x3E8*0x112 -> 0x00042E50.
  - MUL 0xFFFF0000*0xF -> 0xFFF10000.
  - MUL 0xFFFFFFFF*0xFFFFFFFF -> 0x00000001.
  - AND 0xFFFF0000&0xF -> 0, Zero=1.
  - OR 0x3E8|0x112 -> 0x000003FA.
- Compare:
  - SLT 0x3E8,0x112 -> 0.
  - SLT 0x112,0x3E8 -> 1.
  - SLT 0xFFFFFFFF,0x1 -> 1 (signed).
  - SLT equal operands -> 0.
  - SEQ 0xFFFFFFFF,0xFFFFFFFF -> 1.
  - SNE same operands -> 0.
- Shift/rotate with A=0xFED:
  - SRL by 1 -> 0x7F6; SRL by 10 -> 0x3.
  - SLL by 1 -> 0x1FDA; SLL by 10 -> 0x003FB400.
  - ROTR by 1 -> 0x800007F6; ROTR by 10 -> 0xFB400003.
- Counts:
  - CLO 0xFFFFFFF1 -> 28; CLO 0xFFFFFFFF -> 32; CLO 0x00000003 -> 0.
  - CLZ 0x00000003 -> 30; CLZ 0x08000003 -> 4; CLZ 0xC0000003 -> 0; CLZ 0 -> 32.
  - Back-to-back opcode changes each cycle -> every result appears exactly one edge after its inputs.
